// File: rtl/rv_dispatch_pkg.sv
// rv_dispatch_pkg: shared opcode constants for the R-type dispatch path
package rv_dispatch_pkg;
  localparam int RV_OPCODE_WIDTH = 7;
  localparam logic [RV_OPCODE_WIDTH-1:0] OPC_RTYPE = 7'b0110011;
  function automatic logic is_rtype(input logic [RV_OPCODE_WIDTH-1:0] opc);
    return opc == OPC_RTYPE;
  endfunction
endpackage

// File: rtl/rtype_dispatch_sched_pend_pick.sv
// pend_pick: indices of the lowest LANES set bits of pend, in ascending order
module pend_pick #(
  parameter int IPC = 4,
  parameter int LANES = 2,
  parameter int SLOT_WIDTH = $clog2(IPC)
) (
  input  logic [IPC-1:0]              pend,
  output logic [LANES*SLOT_WIDTH-1:0] pick_idx,
  output logic [LANES-1:0]            pick_vld
);
  logic [IPC-1:0] rem;
  always_comb begin
    rem = pend;
    pick_idx = '0;
    pick_vld = '0;
    for (int k = 0; k < LANES; k++) begin
      pick_vld[k] = |rem;
      for (int i = IPC - 1; i >= 0; i--)
        if (rem[i]) pick_idx[k*SLOT_WIDTH +: SLOT_WIDTH] = SLOT_WIDTH'(i);
      rem = rem & (rem - IPC'(1));
    end
  end
endmodule

// File: rtl/rtype_dispatch_sched.sv
// rtype_dispatch_sched: filters R-type slots of a fetch bundle and issues them in order, LANES per group.
// Define RDISP_STALL_CNT_EN to add the saturating stall_cnt output.
module rtype_dispatch_sched
  import rv_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IPC = 4,
  parameter int LANES = 2,
  parameter int TAG_WIDTH = 7,
  parameter int SLOT_WIDTH = $clog2(IPC),
  parameter int OPCODE_WIDTH = RV_OPCODE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [IPC*DATA_WIDTH-1:0]   bundle_data,
  input  logic [IPC-1:0]              bundle_mask,
  input  logic                        bundle_valid,
  output logic                        bundle_ready,
  output logic [LANES-1:0]            lane_valid,
  input  logic [LANES-1:0]            lane_ready,
  output logic [LANES*DATA_WIDTH-1:0] lane_data,
  output logic [LANES*TAG_WIDTH-1:0]  lane_tag,
  output logic [LANES*SLOT_WIDTH-1:0] lane_slot
`ifdef RDISP_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);
  logic [DATA_WIDTH-1:0]       slot_q [IPC];
  logic [IPC-1:0]              pend;
  logic [IPC-1:0]              is_r;
  logic [IPC-1:0]              taken;
  logic [TAG_WIDTH-1:0]        tag_cnt;
  logic [TAG_WIDTH-1:0]        n;
  logic [LANES*SLOT_WIDTH-1:0] pick_idx;
  logic [LANES-1:0]            pick_vld;
  logic [LANES*DATA_WIDTH-1:0] ld;
  logic [LANES*TAG_WIDTH-1:0]  lt;
  logic                        free;

  pend_pick #(.IPC(IPC), .LANES(LANES), .SLOT_WIDTH(SLOT_WIDTH)) u_pick (
    .pend(pend),
    .pick_idx(pick_idx),
    .pick_vld(pick_vld)
  );

  assign bundle_ready = pend == '0;
  assign free = &(~lane_valid | lane_ready);

  always_comb begin
    is_r = '0;
    for (int i = 0; i < IPC; i++)
      is_r[i] = bundle_mask[i] && is_rtype(bundle_data[i*DATA_WIDTH +: OPCODE_WIDTH]);
  end

  always_comb begin
    taken = '0;
    ld = '0;
    lt = '0;
    n = '0;
    for (int k = 0; k < LANES; k++) begin
      ld[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[pick_idx[k*SLOT_WIDTH +: SLOT_WIDTH]];
      lt[k*TAG_WIDTH +: TAG_WIDTH] = tag_cnt + TAG_WIDTH'(k);
      taken = taken | (pick_vld[k] ? IPC'(1) << pick_idx[k*SLOT_WIDTH +: SLOT_WIDTH] : '0);
      n = n + TAG_WIDTH'(pick_vld[k]);
    end
  end

  // Capture needs pend == 0 and a load needs pend != 0, so the two pend writes never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IPC; i++) slot_q[i] <= '0;
      pend <= '0;
      lane_valid <= '0;
      lane_data <= '0;
      lane_tag <= '0;
      lane_slot <= '0;
      tag_cnt <= '0;
    end else if (flush) begin
      pend <= '0;
      lane_valid <= '0;
    end else begin
      if (bundle_valid && bundle_ready) begin
        for (int i = 0; i < IPC; i++) slot_q[i] <= bundle_data[i*DATA_WIDTH +: DATA_WIDTH];
        pend <= is_r;
      end
      if (free) begin
        lane_valid <= pick_vld;
        if (pend != '0) begin
          lane_data <= ld;
          lane_tag <= lt;
          lane_slot <= pick_idx;
          pend <= pend & ~taken;
          tag_cnt <= tag_cnt + n;
        end
      end else begin
        lane_valid <= lane_valid & ~lane_ready;
      end
    end
  end

`ifdef RDISP_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (flush) stall_cnt <= '0;
    else if (|(lane_valid & ~lane_ready) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/rtype_dispatch_sched.md
# rtype_dispatch_sched

Dispatch scheduler between the fetch unit and the R-type decode/execute lanes. It accepts one fetch bundle of IPC instruction slots and filters the R-type slots (opcode 7'b0110011). It issues them in program order over LANES registered output lanes, one group per cycle, and stamps each issued instruction with a wrapping sequence tag. Non-R-type slots are dropped from this path; the other decoders handle them.

## Interface
- DATA_WIDTH, 32, instruction width
- IPC, 4, slots per fetch bundle
- LANES, 2, R-type issue lanes (1..IPC)
- TAG_WIDTH, 7, sequence tag width
- SLOT_WIDTH, $clog2(IPC), bundle slot index width
- OPCODE_WIDTH, 7, opcode field width at bits [6:0]

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous discard of all held work
- bundle_data  input  IPC*DATA_WIDTH  slot i at [i*DATA_WIDTH +: DATA_WIDTH]; slot 0 is oldest
- bundle_mask  input  IPC  per-slot valid
- bundle_valid  input  1  bundle offered
- bundle_ready  output  1  bundle accepted when valid&&ready
- lane_valid  output  LANES  lane k holds an instruction
- lane_ready  input  LANES  downstream accepts lane k
- lane_data  output  LANES*DATA_WIDTH  instruction on lane k
- lane_tag  output  LANES*TAG_WIDTH  sequence tag on lane k
- lane_slot  output  LANES*SLOT_WIDTH  originating bundle slot on lane k

## Operation
- **Pending mask.** pend[IPC] and the bundle buffer are registers. bundle_ready = (pend == 0), combinational.
- **Capture.** On bundle_valid && bundle_ready, buffer <= bundle_data and pend[i] <= bundle_mask[i] && opcode(slot i) == R-type. A bundle with no R-type slots is consumed and pend stays 0.
- **Lane free.** free = AND over k of (!lane_valid[k] || lane_ready[k]).
- **Group load.** When free and pend != 0:
  - the lowest-indexed n = min(LANES, popcount(pend)) pending slots load into lanes 0..n-1 in ascending slot order;
  - lane k gets tag = tag_cnt + k;
  - those pend bits clear, lanes n..LANES-1 go invalid, and tag_cnt += n, mod 2^TAG_WIDTH.
- **Idle.** When free and pend == 0, all lanes go invalid.
- **Stall.** When !free, lane contents hold. Any lane with valid && ready clears its own valid, and the next group waits until every lane is free. Groups therefore never mix, and tags on the lane outputs are strictly increasing in time.
- **Data stability.** While lane_valid is high, lane_data, lane_tag and lane_slot are stable.
- **Flush.** flush clears pend and all lane_valid at the next edge. It overrides capture and load in the same cycle, and bundle_ready is ignored that cycle. tag_cnt is not reset.
- **Reset.** pend = 0, lane_valid = 0, lane_data/lane_tag/lane_slot = 0, tag_cnt = 0, bundle_ready = 1. Reset asserted mid-operation discards everything immediately.

## Timing
- Capture at edge E0; first group is visible after E1, the next group after E2 (with all ready), and so on.
- bundle_ready rises in the cycle after the edge that clears the last pend bit.
- Example with 4 R-type slots, LANES=2, ready held high: bundle accepted every 3 cycles.
- Capture and group load never occur at the same edge, because capture requires pend == 0.
- tag_cnt wraps from 2^TAG_WIDTH-1 to 0 with no gap.

## Configuration
- RDISP_STALL_CNT_EN defined:
  - adds output stall_cnt [15:0], reset 0;
  - increments on every cycle where any lane_valid[k] && !lane_ready[k];
  - saturates at 16'hFFFF and clears on flush.
- Not defined: the port and its logic are absent.

## Structure
- Shared package rv_dispatch_pkg: R-type opcode constant 7'b0110011 and the opcode field width.
- Sub-module pend_pick: combinational. Input is pend[IPC]; outputs are the indices and valid bits of the lowest LANES set bits, in order.

## Test plan
- **Full bundle:** reset, then bundle of 4 R-type slots (mask 4'b1111), ready all 1 -> lanes carry slots 0,1 with tags 0,1 after E1; slots 2,3 with tags 2,3 after E2; bundle_ready=1 after E2.
- **Filtering:** mask 4'b1111 with slots 1,3 non-R-type -> a single group with slot 0 on lane 0 (tag 0) and slot 2 on lane 1 (tag 1).
- **Partial stall:** lane_ready=2'b01 for 3 cycles with 4 R-types -> lane 0 drops valid after one cycle, lane 1 holds its data/tag stable, and slots 2,3 load only in the cycle after lane_ready[1] rises.
- **Tag wrap:** issue 130 R-type instructions -> tags run 0..127, 0, 1, with no duplicate within each window.
- **Flush:** flush during a pending second group -> lane_valid=0 and bundle_ready=1 next cycle; the next bundle continues tags from the uncleared counter.
- **Reset mid-group:** assert rst=0 asynchronously while lanes are valid -> all outputs go to reset values without waiting for a clock edge.
